// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline.
// Produces EX-stage forwarding selects, per-stage stall/flush strobes for
// load-use, taken control transfers and slow data-memory accesses, a sticky
// memory-timeout flag and saturating stall/flush activity counters.
//
// Handshake: dmem_req_m_hu acts as valid and dmem_ready_hu as ready. An
// access completes on a cycle where both are high; the requester keeps
// dmem_req_m_hu high until then, and any cycle with req high and ready low
// is a memory-wait cycle. Dropping req without ready abandons the access.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_hu,
    input  logic             rst_hu,
    input  logic [4:0]       rs1_d_hu,
    input  logic [4:0]       rs2_d_hu,
    input  logic [4:0]       rs1_e_hu,
    input  logic [4:0]       rs2_e_hu,
    input  logic [4:0]       rd_e_hu,
    input  logic [4:0]       rd_m_hu,
    input  logic [4:0]       rd_w_hu,
    input  logic             reg_write_e_hu,
    input  logic             reg_write_m_hu,
    input  logic             reg_write_w_hu,
    input  logic [1:0]       result_src_e_hu,
    input  logic             pc_src_e_hu,
    input  logic             dmem_req_m_hu,
    input  logic             dmem_ready_hu,
    input  logic             clr_cnt_hu,
    output logic [1:0]       forward_a_e_hu,
    output logic [1:0]       forward_b_e_hu,
    output logic             stall_f_hu,
    output logic             stall_d_hu,
    output logic             stall_e_hu,
    output logic             stall_m_hu,
    output logic             flush_d_hu,
    output logic             flush_e_hu,
    output logic             flush_w_hu,
    output logic             mem_err_hu,
    output logic [CNT_W-1:0] stall_cnt_hu,
    output logic [CNT_W-1:0] flush_cnt_hu,
    output logic             dbg_state_hu
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] SRC_LOAD = 2'b01;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q;
    logic            timeout_hit;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic mem_pending;  // access outstanding and not completing this cycle
    logic mem_stall;    // pipeline must hold for the memory this cycle
    logic load_use;

    // M result is newer than W, so it wins when both target the operand.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (reg_write_m_hu && (rd_m_hu != 5'd0) && (rd_m_hu == src))
            sel = FWD_M;
        else if (reg_write_w_hu && (rd_w_hu != 5'd0) && (rd_w_hu == src))
            sel = FWD_W;
        return sel;
    endfunction

    // Operand forwarding selects for the instruction in E.
    always_comb begin
        forward_a_e_hu = fwd_sel(rs1_e_hu);
        forward_b_e_hu = fwd_sel(rs2_e_hu);
    end

    // Hazard detection: load-use against D sources, and memory wait that is
    // still within its cycle budget (the timeout cycle itself releases).
    always_comb begin
        load_use = reg_write_e_hu && (result_src_e_hu == SRC_LOAD) &&
                   (rd_e_hu != 5'd0) &&
                   ((rd_e_hu == rs1_d_hu) || (rd_e_hu == rs2_d_hu));
        mem_pending = dmem_req_m_hu && !dmem_ready_hu;
        mem_stall   = mem_pending &&
                      ((state_q == ST_RUN) || (wait_cnt_q < TIMEOUT_V));
    end

    // Strobe priority: memory wait, then taken branch (D is wrong-path, so
    // it beats load-use), then load-use.
    always_comb begin
        stall_f_hu = 1'b0;
        stall_d_hu = 1'b0;
        stall_e_hu = 1'b0;
        stall_m_hu = 1'b0;
        flush_d_hu = 1'b0;
        flush_e_hu = 1'b0;
        flush_w_hu = 1'b0;
        if (mem_stall) begin
            stall_f_hu = 1'b1;
            stall_d_hu = 1'b1;
            stall_e_hu = 1'b1;
            stall_m_hu = 1'b1;
            flush_w_hu = 1'b1;
        end else if (pc_src_e_hu) begin
            flush_d_hu = 1'b1;
            flush_e_hu = 1'b1;
        end else if (load_use) begin
            stall_f_hu = 1'b1;
            stall_d_hu = 1'b1;
            flush_e_hu = 1'b1;
        end
    end

    // Memory-wait FSM next state: wait_cnt counts stall cycles of the access.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_pending) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_pending) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_V) begin
                    state_d     = ST_RUN;
                    wait_cnt_d  = '0;
                    timeout_hit = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM state register and sticky timeout flag.
    always_ff @(posedge clk_hu or negedge rst_hu) begin
        if (!rst_hu) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_hit)
                mem_err_q <= 1'b1;
        end
    end

    // Saturating activity counters; clear beats increment.
    always_ff @(posedge clk_hu or negedge rst_hu) begin
        if (!rst_hu) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (clr_cnt_hu) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f_hu && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (pc_src_e_hu && !mem_stall && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    // Registered status outputs.
    always_comb begin
        mem_err_hu   = mem_err_q;
        stall_cnt_hu = stall_cnt_q;
        flush_cnt_hu = flush_cnt_q;
        dbg_state_hu = state_q;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised and directed bench for hazard_unit with a scoreboard queue.
module tb_hazard_unit;

  localparam int MT = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_hu = 1'b0;

  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic rw_e, rw_m, rw_w, pc_src, dmem_req, dmem_ready, clr_cnt;
  logic [1:0] result_src;
  logic [1:0] forward_a, forward_b;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic mem_err, dbg_state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_hu(clk), .rst_hu(rst_hu),
    .rs1_d_hu(rs1_d), .rs2_d_hu(rs2_d), .rs1_e_hu(rs1_e), .rs2_e_hu(rs2_e),
    .rd_e_hu(rd_e), .rd_m_hu(rd_m), .rd_w_hu(rd_w),
    .reg_write_e_hu(rw_e), .reg_write_m_hu(rw_m), .reg_write_w_hu(rw_w),
    .result_src_e_hu(result_src), .pc_src_e_hu(pc_src),
    .dmem_req_m_hu(dmem_req), .dmem_ready_hu(dmem_ready), .clr_cnt_hu(clr_cnt),
    .forward_a_e_hu(forward_a), .forward_b_e_hu(forward_b),
    .stall_f_hu(stall_f), .stall_d_hu(stall_d), .stall_e_hu(stall_e), .stall_m_hu(stall_m),
    .flush_d_hu(flush_d), .flush_e_hu(flush_e), .flush_w_hu(flush_w),
    .mem_err_hu(mem_err), .stall_cnt_hu(stall_cnt), .flush_cnt_hu(flush_cnt),
    .dbg_state_hu(dbg_state)
  );

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rw_e, rw_m, rw_w;
    logic [1:0] result_src;
    logic       pc_src, req, ready, clr;
  } stim_t;

  // scoreboard: {fwd_a, fwd_b, strobes[6:0], waiting, mem_err, stall_cnt, flush_cnt}
  logic [20:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: an access may stall for at most MT consecutive cycles
  int m_streak = 0;
  bit m_err = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input stim_t s);
    if (s.rw_m && s.rd_m != 0 && s.rd_m == src) return 2'b10;
    if (s.rw_w && s.rd_w != 0 && s.rd_w == src) return 2'b01;
    return 2'b00;
  endfunction

  // driver: apply one cycle of inputs and push the expected response
  task automatic drive(input stim_t s_in, input bit rst_val);
    stim_t s;
    logic [6:0] st;
    logic [20:0] e;
    bit pend, ms, lu;
    int sc, fc;
    s = rst_val ? s_in : '0;
    @(posedge clk);
    #1;
    rst_hu = rst_val;
    rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e;
    rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
    rw_e = s.rw_e; rw_m = s.rw_m; rw_w = s.rw_w; result_src = s.result_src;
    pc_src = s.pc_src; dmem_req = s.req; dmem_ready = s.ready; clr_cnt = s.clr;
    if (!rst_val) begin
      m_streak = 0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
      e = '0;
    end else begin
      pend = s.req && !s.ready;
      ms = pend && (m_streak < MT);
      lu = s.rw_e && s.result_src == 2'b01 && s.rd_e != 0 &&
           (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
      if (ms) st = 7'b1111_001;
      else if (s.pc_src) st = 7'b0000_110;
      else if (lu) st = 7'b1100_010;
      else st = 7'b0;
      sc = m_scnt; fc = m_fcnt;
      e = {ref_fwd(s.rs1_e, s), ref_fwd(s.rs2_e, s), st, (m_streak > 0), m_err,
           sc[CW-1:0], fc[CW-1:0]};
      if (pend && m_streak == MT) m_err = 1'b1;
      m_streak = ms ? m_streak + 1 : 0;
      if (s.clr) begin
        m_scnt = 0; m_fcnt = 0;
      end else begin
        if (st[6]) m_scnt = (m_scnt < SAT) ? m_scnt + 1 : SAT;
        if (s.pc_src && !ms) m_fcnt = (m_fcnt < SAT) ? m_fcnt + 1 : SAT;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic repeat_drive(input stim_t s, input int n);
    for (int i = 0; i < n; i++) drive(s, 1'b1);
  endtask

  // monitor: outputs are valid every cycle; compare mid-cycle
  logic [20:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({forward_a, forward_b} !== mon_e[20:17]) begin
        errors++;
        $display("FAIL fwd @%0t: got a=%b b=%b want a=%b b=%b", $time,
                 forward_a, forward_b, mon_e[20:19], mon_e[18:17]);
      end
      checks++;
      if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w} !== mon_e[16:10]) begin
        errors++;
        $display("FAIL strobes @%0t: got sfdem/fdew=%b want %b", $time,
                 {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, mon_e[16:10]);
      end
      checks++;
      if ({dbg_state, mem_err, stall_cnt, flush_cnt} !== mon_e[9:0]) begin
        errors++;
        $display("FAIL status @%0t: got wait=%b err=%b scnt=%0d fcnt=%0d want wait=%b err=%b scnt=%0d fcnt=%0d",
                 $time, dbg_state, mem_err, stall_cnt, flush_cnt,
                 mon_e[9], mon_e[8], mon_e[7:4], mon_e[3:0]);
      end
    end
  end

  stim_t s;
  int guard;

  initial begin
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {rw_e, rw_m, rw_w, pc_src, dmem_req, dmem_ready, clr_cnt} = '0;
    result_src = '0;

    // reset
    drive('0, 1'b0);
    drive('0, 1'b0);

    // forwarding: M over W, W alone, x0 never forwarded
    s = '0; s.rd_m = 5; s.rd_w = 5; s.rw_m = 1; s.rw_w = 1; s.rs1_e = 5; s.rs2_e = 5;
    drive(s, 1'b1);
    s.rw_m = 0; drive(s, 1'b1);
    s.rw_m = 1; s.rd_m = 0; s.rd_w = 0; s.rs1_e = 0; s.rs2_e = 0; drive(s, 1'b1);
    s = '0; s.rd_m = 3; s.rd_w = 9; s.rw_m = 1; s.rw_w = 1; s.rs1_e = 9; s.rs2_e = 3;
    drive(s, 1'b1);

    // load-use, then bubble
    s = '0; s.rd_e = 7; s.rw_e = 1; s.result_src = 2'b01; s.rs2_d = 7;
    drive(s, 1'b1);
    drive('0, 1'b1);
    drive('0, 1'b1);

    // branch beats load-use
    s.pc_src = 1; drive(s, 1'b1);
    drive('0, 1'b1);

    // memory wait released by ready
    s = '0; s.req = 1; repeat_drive(s, 3);
    s.ready = 1; drive(s, 1'b1);
    drive('0, 1'b1);

    // timeout, sticky error, then reset during a new wait
    s = '0; s.req = 1; repeat_drive(s, MT + 1);
    repeat_drive('0, 2);
    repeat_drive(s, 2);
    drive('0, 1'b0);
    repeat_drive('0, 2);

    // counter saturation and clear with simultaneous stall
    s = '0; s.rd_e = 4; s.rw_e = 1; s.result_src = 2'b01; s.rs1_d = 4;
    repeat_drive(s, 20);
    s.clr = 1; drive(s, 1'b1);
    repeat_drive('0, 2);

    // randomised traffic
    for (int i = 0; i < 800; i++) begin
      s.rs1_d = 5'($urandom_range(0, 3)); s.rs2_d = 5'($urandom_range(0, 3));
      s.rs1_e = 5'($urandom_range(0, 3)); s.rs2_e = 5'($urandom_range(0, 3));
      s.rd_e = 5'($urandom_range(0, 3)); s.rd_m = 5'($urandom_range(0, 3));
      s.rd_w = 5'($urandom_range(0, 3));
      s.rw_e = 1'($urandom_range(0, 1)); s.rw_m = 1'($urandom_range(0, 1));
      s.rw_w = 1'($urandom_range(0, 1));
      s.result_src = 2'($urandom_range(0, 3));
      s.pc_src = ($urandom_range(0, 3) == 0);
      s.req = 1'($urandom_range(0, 1));
      s.ready = ($urandom_range(0, 3) == 0);
      s.clr = ($urandom_range(0, 60) == 0);
      drive(s, ($urandom_range(0, 150) != 0));
    end
    drive('0, 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. It computes EX-stage operand forwarding selects and generates per-stage stall and flush strobes for load-use hazards, taken control transfers and variable-latency data-memory accesses. A small FSM sequences memory-wait stalls with a timeout. Saturating counters record stall and flush activity. It sits beside the pipeline registers and consumes decode/execute control fields such as `reg_write`, `result_src` and `pc_src`.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive memory-wait stall cycles (≥2).
- `CNT_W`, default 32: width of the performance counters.
- `clk_hu` in 1: core clock, rising edge.
- `rst_hu` in 1: reset, asynchronous, active-low.
- `rs1_d_hu`, `rs2_d_hu` in 5: source registers of the instruction in D.
- `rs1_e_hu`, `rs2_e_hu`, `rd_e_hu` in 5: sources and destination of the instruction in E.
- `rd_m_hu`, `rd_w_hu` in 5: destinations of the instructions in M and W.
- `reg_write_e_hu`, `reg_write_m_hu`, `reg_write_w_hu` in 1: register write enables per stage.
- `result_src_e_hu` in 2: result select of the instruction in E; 2'b01 = memory load.
- `pc_src_e_hu` in 1: a taken branch or jump resolved in E this cycle.
- `dmem_req_m_hu` in 1: the instruction in M is accessing data memory.
- `dmem_ready_hu` in 1: data memory completes the access this cycle.
- `clr_cnt_hu` in 1: synchronous clear of both counters.
- `forward_a_e_hu`, `forward_b_e_hu` out 2: operand select; 00 = register file, 10 = M result, 01 = W result.
- `stall_f_hu`, `stall_d_hu`, `stall_e_hu`, `stall_m_hu` out 1: hold the PC or the named pipeline register.
- `flush_d_hu`, `flush_e_hu`, `flush_w_hu` out 1: load a bubble into the named pipeline register.
- `mem_err_hu` out 1: sticky flag, set when a memory access times out.
- `stall_cnt_hu`, `flush_cnt_hu` out `CNT_W`: stall-cycle count and control-flush count.

## Operation
- **Forwarding (per operand X = rs1_e or rs2_e):**
  - Select 10 if `reg_write_m` && `rd_m` != 0 && `rd_m` == X.
  - Else select 01 if `reg_write_w` && `rd_w` != 0 && `rd_w` == X.
  - Else select 00. M has priority over W.
- **Load-use (lu):** `reg_write_e` && `result_src_e` == 01 && `rd_e` != 0 && (`rd_e` == `rs1_d` || `rd_e` == `rs2_d`).
- **Memory stall (ms):** true in RUN when `dmem_req_m` && !`dmem_ready`. True in WAIT when `dmem_req_m` && !`dmem_ready` && `wait_cnt` < `MEM_TIMEOUT`.
- **Priority, highest first:**
  - ms: `stall_f/d/e/m` = 1, `flush_w` = 1, all other flushes 0.
  - `pc_src_e`: `flush_d` = `flush_e` = 1, no stalls. This overrides lu because D holds a wrong-path instruction.
  - lu: `stall_f` = `stall_d` = 1, `flush_e` = 1.
  - Otherwise all strobes are 0.
- **FSM states:** RUN and WAIT, plus `wait_cnt` (width clog2(`MEM_TIMEOUT`)+1).
  - RUN → WAIT when ms; `wait_cnt` ← 1.
  - In WAIT with `dmem_ready` or !`dmem_req_m`: go to RUN; `wait_cnt` ← 0.
  - In WAIT with `wait_cnt` == `MEM_TIMEOUT` and still not ready: go to RUN; `wait_cnt` ← 0; `mem_err` ← 1. The access is abandoned and the pipeline advances.
  - Otherwise stay in WAIT; `wait_cnt`++.
- **Counters:**
  - `stall_cnt` increments on each cycle with `stall_f` = 1.
  - `flush_cnt` increments on each cycle with `pc_src_e` && !ms.
  - Both saturate at 2^`CNT_W`−1.
  - `clr_cnt` zeroes both and has priority over increment.
  - `mem_err` clears only on reset.

## Timing
- All forwarding, stall and flush outputs are combinational from the current inputs and registered state, valid in the same cycle.
- State, `wait_cnt`, counters and `mem_err` update on the rising edge of `clk_hu`.
- A load-use stall lasts exactly 1 cycle, because E holds a bubble in the following cycle.
- A memory stall lasts at most `MEM_TIMEOUT` cycles: one cycle in RUN plus up to `MEM_TIMEOUT`−1 cycles in WAIT.
- `dmem_ready` asserted in the first request cycle gives zero stall.
- **Reset (async assert):** state RUN, `wait_cnt` 0, counters 0, `mem_err` 0.
- With all inputs 0 during reset, every combinational output is 0.
- Reset asserted mid-WAIT returns to RUN immediately, with no error flagged.

## Test plan
- **Forwarding:** `rd_m` = `rd_w` = 5, both writing, `rs1_e` = 5 → `forward_a` = 10. With `reg_write_m` = 0 → 01. With `rd` = 0 → 00.
- **Load-use:** `rd_e` = 7, `result_src_e` = 01, `rs2_d` = 7 → `stall_f`/`stall_d`/`flush_e` = 1 for one cycle. Next cycle (bubble in E) → all strobes 0; `stall_cnt` = 1.
- **Branch vs. load-use:** same cycle lu and `pc_src_e` = 1 → `flush_d` = `flush_e` = 1, `stall_f` = 0; `flush_cnt` = 1.
- **Memory wait:** `dmem_req` held with ready low 3 cycles then high → stalls and `flush_w` for 3 cycles, release on the ready cycle; `stall_cnt` = 3; no error.
- **Timeout:** `MEM_TIMEOUT` = 4, ready never asserted → stall exactly 4 cycles, then released; `mem_err` = 1 after the next edge and stays set. Reset mid-wait (second cycle) → outputs 0 asynchronously, `mem_err` 0.
- **Counter saturation:** `CNT_W` = 4, 20 stall cycles → `stall_cnt` = 15. `clr_cnt` with a simultaneous stall → 0.
